// File: rtl/rf_writeback_queue_if.sv
// rf_writeback_queue_if
// Handshake and drain bundle between write-result producers, the writeback
// queue and the register file write port.
//   in_valid/in_reg/in_data/in_ready : producer push handshake
//   drain_hold                       : suppresses draining this cycle
//   writeRegSel/writeData/writeEn    : register file write port
// Modports: slave = the queue, master = the surrounding pipeline/register file.
interface rf_writeback_queue_if;
    logic        in_valid;
    logic [2:0]  in_reg;
    logic [15:0] in_data;
    logic        in_ready;
    logic        drain_hold;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;

    modport slave (
        input  in_valid, in_reg, in_data, drain_hold,
        output in_ready, writeRegSel, writeData, writeEn
    );

    modport master (
        output in_valid, in_reg, in_data, drain_hold,
        input  in_ready, writeRegSel, writeData, writeEn
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
// In-order writeback buffer in front of the 8x16b register file write port.
// Accepted results are stored in a circular FIFO and drained one per cycle,
// oldest first. A per-register pending mask flags registers that still have
// a queued write so hazard logic can stall their readers.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : push handshake, drain_hold, register file write port
//   pending [7:0]   : bit r set while any stored entry targets register r
//   count           : number of stored entries (0..DEPTH)
//   lookup1Sel/lookup2Sel, lookup1Hit/lookup2Hit, lookup1Data/lookup2Data :
//                     forwarding queries, present only when WBQ_FWD_EN is defined
//
// Build option: define WBQ_FWD_EN to add the combinational forwarding lookup
// (youngest matching entry wins). Without it readers must stall on pending.
module rf_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rf_writeback_queue_if.slave      bus,
    output logic [7:0]               pending,
`ifdef WBQ_FWD_EN
    input  logic [2:0]               lookup1Sel,
    input  logic [2:0]               lookup2Sel,
    output logic                     lookup1Hit,
    output logic                     lookup2Hit,
    output logic [15:0]              lookup1Data,
    output logic [15:0]              lookup2Data,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [2:0]  reg_mem  [DEPTH];
    logic [15:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;

    logic push;
    logic pop;
    logic [DEPTH-1:0] slot_valid;

    // Full blocks acceptance even if a pop happens in the same cycle, so the
    // ready path never depends on drain_hold.
    assign bus.in_ready    = (cnt != (PW+1)'(DEPTH));
    assign bus.writeEn     = (cnt != '0) & ~bus.drain_hold;
    assign bus.writeRegSel = (cnt != '0) ? reg_mem[head]  : 3'd0;
    assign bus.writeData   = (cnt != '0) ? data_mem[head] : 16'd0;
    assign count           = cnt;

    assign push = bus.in_valid & bus.in_ready & ~rst;
    assign pop  = bus.writeEn & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset: a slot only matters while it lies inside the
    // head..head+cnt window.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[tail]  <= bus.in_reg;
            data_mem[tail] <= bus.in_data;
        end
    end

    // Slot i is live when its distance from head (mod DEPTH) is below cnt.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = ({1'b0, PW'(i) - head} < cnt);
        end
    end

    always_comb begin
        pending = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pending[reg_mem[i]] = 1'b1;
        end
    end

`ifdef WBQ_FWD_EN
    // Walk from oldest to youngest so the last match seen is the youngest.
    logic [PW-1:0] fwd_idx;

    always_comb begin
        lookup1Hit  = 1'b0;
        lookup1Data = 16'd0;
        lookup2Hit  = 1'b0;
        lookup2Data = 16'd0;
        fwd_idx     = head;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if ((PW+1)'(k) < cnt) begin
                if (reg_mem[fwd_idx] == lookup1Sel) begin
                    lookup1Hit  = 1'b1;
                    lookup1Data = data_mem[fwd_idx];
                end
                if (reg_mem[fwd_idx] == lookup2Sel) begin
                    lookup2Hit  = 1'b1;
                    lookup2Data = data_mem[fwd_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based reference of the writeback buffer.
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] pending;
    logic [2:0] count;
    logic [2:0] lookup1Sel;
    logic [2:0] lookup2Sel;
`ifdef WBQ_FWD_EN
    logic        lookup1Hit;
    logic        lookup2Hit;
    logic [15:0] lookup1Data;
    logic [15:0] lookup2Data;
`endif

    int total = 0;
    int bad   = 0;

    logic [18:0] q [$];

    rf_writeback_queue_if bus ();

    rf_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pending     (pending),
`ifdef WBQ_FWD_EN
        .lookup1Sel  (lookup1Sel),
        .lookup2Sel  (lookup2Sel),
        .lookup1Hit  (lookup1Hit),
        .lookup2Hit  (lookup2Hit),
        .lookup1Data (lookup1Data),
        .lookup2Data (lookup2Data),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_pending();
        logic [7:0] m = 8'h00;
        foreach (q[i]) m[q[i][18:16]] = 1'b1;
        return m;
    endfunction

`ifdef WBQ_FWD_EN
    function automatic logic [16:0] model_lookup(input logic [2:0] sel);
        logic [16:0] r = 17'd0;
        foreach (q[i]) if (q[i][18:16] == sel) r = {1'b1, q[i][15:0]};
        return r;
    endfunction
`endif

    // One clock cycle: drive inputs, check all outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input logic [2:0] rg,
                        input logic [15:0] d, input logic h);
        logic acc;
        logic drn;
        logic [18:0] hd;
        @(negedge clk);
        rst            = r;
        bus.in_valid   = v;
        bus.in_reg     = rg;
        bus.in_data    = d;
        bus.drain_hold = h;
        lookup1Sel     = 3'($urandom_range(0, 7));
        lookup2Sel     = 3'($urandom_range(0, 7));
        #1;
        hd = (q.size() != 0) ? q[0] : 19'd0;
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
        chk("writeEn", 32'(bus.writeEn), 32'((q.size() != 0) && !h));
        chk("writeRegSel", 32'(bus.writeRegSel), 32'(hd[18:16]));
        chk("writeData", 32'(bus.writeData), 32'(hd[15:0]));
        chk("pending", 32'(pending), 32'(model_pending()));
        chk("count", 32'(count), 32'(q.size()));
`ifdef WBQ_FWD_EN
        chk("lookup1", {15'd0, lookup1Hit, lookup1Data}, 32'(model_lookup(lookup1Sel)));
        chk("lookup2", {15'd0, lookup2Hit, lookup2Data}, 32'(model_lookup(lookup2Sel)));
`endif
        acc = v && !r && (q.size() != DEPTH);
        drn = (q.size() != 0) && !h && !r;
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({rg, d});
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_reg = 3'd0;
        bus.in_data = 16'd0;
        bus.drain_hold = 1'b0;
        lookup1Sel = 3'd0;
        lookup2Sel = 3'd0;

        // reset, with a push presented during reset that must be dropped
        step(1, 0, 0, 0, 0);
        step(1, 1, 3'd2, 16'h1234, 0);
        step(0, 0, 0, 0, 0);

        // single push, drained on the next cycle
        step(0, 1, 3'd3, 16'hBEEF, 0);
        chk("beef_we", 32'(bus.writeEn), 32'd1);
        chk("beef_sel", 32'(bus.writeRegSel), 32'd3);
        chk("beef_data", 32'(bus.writeData), 32'hBEEF);
        chk("beef_pend", 32'(pending), 32'h08);
        step(0, 0, 0, 0, 0);
        chk("beef_pend_clr", 32'(pending), 32'h00);

        // fill under hold, fifth push refused, then ordered drain
        for (int i = 1; i <= 4; i++) step(0, 1, 3'(i), 16'(16'hA000 + i), 1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_pend", 32'(pending), 32'h1E);
        step(0, 1, 3'd7, 16'h5555, 1);
        chk("full_count2", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        // streaming across the pointer wrap
        step(0, 1, 3'd0, 16'h0100, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 3'(i), 16'(16'h0100 + i), 0);
            chk("stream_count", 32'(count), 32'd1);
        end
        step(0, 0, 0, 0, 0);

        // same register queued twice
        step(0, 1, 3'd5, 16'h0001, 1);
        step(0, 1, 3'd5, 16'h0002, 1);
`ifdef WBQ_FWD_EN
        @(negedge clk);
        lookup1Sel = 3'd5;
        lookup2Sel = 3'd6;
        #1;
        chk("fwd1_hit", 32'(lookup1Hit), 32'd1);
        chk("fwd1_data", 32'(lookup1Data), 32'h0002);
        chk("fwd2_hit", 32'(lookup2Hit), 32'd0);
        chk("fwd2_data", 32'(lookup2Data), 32'h0000);
`endif
        step(0, 0, 0, 0, 0);
        chk("r5_pend_a", 32'(pending[5]), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("r5_pend_b", 32'(pending[5]), 32'd0);

        // reset with entries queued
        for (int i = 0; i < 3; i++) step(0, 1, 3'(i + 4), 16'(16'hC000 + i), 1);
        chk("pre_rst_count", 32'(count), 32'd3);
        step(1, 0, 0, 0, 1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pend", 32'(pending), 32'h00);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 ($urandom_range(0, 9) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
